// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded multi-port register file.
// The REGFILE_BYPASS_EN build option is handled in regfile_mp_sb.sv.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_NUM_READ = 2;
    localparam int ZERO_REG         = 0;

    // Port k of a packed bus of width-bit fields starts at bit k*width.
    function automatic int unsigned field_lsb(input int unsigned index, input int unsigned width);
        return index * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by an issuing instruction, cleared by write-back.
// Register 0 is never marked pending.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_en,
    input  logic [ADDR_W-1:0]   clear_reg,
    input  logic                reserve_en,
    input  logic [ADDR_W-1:0]   reserve_reg,
    output logic [NUM_REGS-1:0] pending
);

    // The reserve is applied after the clear so a new producer wins on a shared index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (clear_en && (clear_reg != ADDR_W'(ZERO_REG)))
                pending[clear_reg] <= 1'b0;
            if (reserve_en && (reserve_reg != ADDR_W'(ZERO_REG)))
                pending[reserve_reg] <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Register file with NUM_READ combinational read ports, one write port and a scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_READ = DEFAULT_NUM_READ
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   RegWrite,
    input  logic [$clog2(NUM_REGS)-1:0]            write_reg,
    input  logic [DATA_W-1:0]                      write_data,
    input  logic [NUM_READ*$clog2(NUM_REGS)-1:0]   read_reg,
    output logic [NUM_READ*DATA_W-1:0]             read_data,
    input  logic                                   reserve_en,
    input  logic [$clog2(NUM_REGS)-1:0]            reserve_reg,
    output logic [NUM_READ-1:0]                    read_busy,
    output logic [NUM_REGS-1:0]                    pending
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_active;

    assign write_active = RegWrite && (write_reg != ADDR_W'(ZERO_REG));

    // Register 0 is cleared by reset and never written, so it always reads as zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (write_active) begin
            regs[write_reg] <= write_data;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .clear_en    (RegWrite),
        .clear_reg   (write_reg),
        .reserve_en  (reserve_en),
        .reserve_reg (reserve_reg),
        .pending     (pending)
    );

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_W-1:0] idx;
        assign idx = read_reg[field_lsb(k, ADDR_W) +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        // A matching in-flight write is forwarded and is no longer considered busy.
        logic fwd;
        assign fwd = write_active && (idx == write_reg);
        assign read_data[field_lsb(k, DATA_W) +: DATA_W] = reset ? '0 : (fwd ? write_data : regs[idx]);
        assign read_busy[k] = reset ? 1'b0 : (fwd ? 1'b0 : pending[idx]);
`else
        assign read_data[field_lsb(k, DATA_W) +: DATA_W] = reset ? '0 : regs[idx];
        assign read_busy[k] = reset ? 1'b0 : pending[idx];
`endif
    end

endmodule
